// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared types and constants for the multi-byte add sequencer and its 8-bit adder.
package multibyte_add_sequencer_pkg;

    localparam int unsigned LIMB_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_e;

    // Limb index width; a single-limb operand still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// Operand-in / result-out handshake bundle for the multi-byte add sequencer.
interface multibyte_add_sequencer_if
    import multibyte_add_sequencer_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [LIMB_W*NBYTES-1:0]   in_a;
    logic [LIMB_W*NBYTES-1:0]   in_b;
    logic                       in_cin;

    logic                       out_valid;
    logic                       out_ready;
    logic [LIMB_W*NBYTES-1:0]   out_sum;
    logic                       out_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/verified_adder_8bit.sv
// Purely combinational 8-bit ripple-carry adder; wired to the sequencer's add_* ports by the enclosing level.
module verified_adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic [8:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int unsigned i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[8];
    end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Feeds an external 8-bit adder one limb per cycle (LSB first), chaining carry through a register,
// and returns the full-width sum plus final carry over a valid/ready handshake.
module multibyte_add_sequencer
    import multibyte_add_sequencer_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    multibyte_add_sequencer_if.slave    bus,
    output logic [LIMB_W-1:0]           add_a,
    output logic [LIMB_W-1:0]           add_b,
    output logic                        add_cin,
    input  logic [LIMB_W-1:0]           add_sum,
    input  logic                        add_cout
);

    localparam int unsigned W     = LIMB_W * NBYTES;
    localparam int unsigned IDX_W = idx_width(NBYTES);

    add_seq_state_e     state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        sum_d         = sum_q;
        carry_d       = carry_q;
        idx_d         = idx_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        add_a         = '0;
        add_b         = '0;
        add_cin       = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                add_cin = carry_q;
                // Decoded limb select/merge keeps the part-select offsets constant per branch.
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    if (IDX_W'(i) == idx_q) begin
                        add_a                       = a_q[i*LIMB_W +: LIMB_W];
                        add_b                       = b_q[i*LIMB_W +: LIMB_W];
                        sum_d[i*LIMB_W +: LIMB_W]   = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == IDX_W'(NBYTES - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.out_sum  = sum_q;
    assign bus.out_cout = carry_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench for multibyte_add_sequencer (NBYTES=4) driving a real 8-bit adder.
module tb_multibyte_add_sequencer;

    localparam int unsigned NB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multibyte_add_sequencer_if #(.NBYTES(NB)) bus ();

    logic [7:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;

    multibyte_add_sequencer #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    verified_adder_8bit u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] es;
        logic        ec;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    time  acc_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result scoreboard: a transfer happens at the posedge following this negedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got out_valid=1 sum=0x%0h expected no pending result at %0t",
                         bus.out_sum, $time);
            end else begin
                e = sb.pop_front();
                chk("out_sum", {32'd0, bus.out_sum}, {32'd0, e.sum});
                chk("out_cout", {63'd0, bus.out_cout}, {63'd0, e.cout});
            end
        end
    end

    // Called just after a posedge; returns 1 time unit after the acceptance edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [31:0] es, input logic ec, input bit track, input bit hold);
        int unsigned w;
        bit          acc;
        exp_t        e;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        w   = 0;
        acc = 1'b0;
        while (!acc && w < 50) begin
            @(negedge clk);
            acc = bus.in_ready && !rst;
            @(posedge clk);
            w++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", w);
        end else begin
            acc_t = $time;
            if (track) begin
                e.sum  = es;
                e.cout = ec;
                sb.push_back(e);
            end
        end
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        time         t1;
        time         prev_t;
        logic [3:0]  cin_pat;
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] full;
        int unsigned w;
        int          vcnt;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        tbl[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_sum", {32'd0, bus.out_sum}, 64'd0);
        chk("rst_out_cout", {63'd0, bus.out_cout}, 64'd0);
        chk("rst_add_a", {56'd0, add_a}, 64'd0);
        chk("rst_add_b", {56'd0, add_b}, 64'd0);
        chk("rst_add_cin", {63'd0, add_cin}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].es, tbl[i].ec, 1'b1, 1'b0);
            drain();
        end

        // Carry ripple with latency check: valid first seen after edge T+4.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("ripple_valid_k%0d", k), {63'd0, bus.out_valid}, (k == 4) ? 64'd1 : 64'd0);
        end
        drain();

        // Carry-in propagation, probing add_cin each RUN cycle.
        cin_pat = 4'b0001;
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("cin_probe_k%0d", k), {63'd0, add_cin}, {63'd0, cin_pat[k]});
        end
        drain();

        // Backpressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.out_valid && w < 20);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_out_sum", {32'd0, bus.out_sum}, 64'd0);
            chk("bp_out_cout", {63'd0, bus.out_cout}, 64'd1);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("bp_release_out_valid", {63'd0, bus.out_valid}, 64'd0);
        drain();

        // in_valid with a new operand during RUN must not be captured early.
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b1, 1'b1);
        t1 = acc_t;
        send(32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        chk("ignored_accept_interval", acc_t - t1, 64'd60);
        drain();

        // Reset during the second RUN cycle aborts the operation.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_add_a", {56'd0, add_a}, 64'd0);
        chk("abort_add_b", {56'd0, add_b}, 64'd0);
        chk("abort_add_cin", {63'd0, add_cin}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
        end
        chk("abort_no_valid", vcnt, 64'd0);
        @(posedge clk);
        #1;

        // Random back-to-back with in_valid held high.
        prev_t = 0;
        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            send(ra, rb, rc, full[31:0], full[32], 1'b1, 1'b1);
            if (i > 0) chk("b2b_interval", acc_t - prev_t, 64'd60);
            prev_t = acc_t;
        end
        bus.in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
